// File: rtl/corr_master_ctrl_if.sv
// Host command and snapshot readout handshakes of the correlator master controller.
interface corr_master_ctrl_if;
    logic        host_cmd_valid;
    logic [31:0] host_cmd;
    logic        host_cmd_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;

    modport master (
        output host_cmd_valid, host_cmd, rd_ready,
        input  host_cmd_ready, rd_data, rd_valid, rd_last
    );

    modport slave (
        input  host_cmd_valid, host_cmd, rd_ready,
        output host_cmd_ready, rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/corr_master_ctrl.sv
// Correlator master: writes the control register, pulses the correlator reset,
// and streams a frozen snapshot of the five accumulators as ten 32-bit words.
//
// state     | meaning
// IDLE      | ready for a host command
// WRITE     | corr_we strobe cycle
// ACK_WAIT  | waiting for sr_in[0] or timeout
// RST_PULSE | corr_reset held high for arg[7:0]+1 cycles
// SNAP      | accumulators copied to shadow
// STREAM    | shadow words handed out on rd_*
module corr_master_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    corr_master_ctrl_if.slave   host,
    output logic [31:0]         corr_cr,
    output logic                corr_we,
    output logic                corr_reset,
    input  logic [31:0]         sr_in,
    input  logic [63:0]         sum_x_2,
    input  logic [63:0]         sum_y_2,
    input  logic [63:0]         sum_xy,
    input  logic [63:0]         sum_xy90,
    input  logic [63:0]         sum_y90_2,
    output logic                busy,
    output logic                err
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WRITE, ACK_WAIT, RST_PULSE, SNAP, STREAM
    } state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       pulse_cnt;
    logic [3:0]       word_idx;
    logic [31:0]      shadow [10];

    logic        accept;
    logic [3:0]  opcode;
    logic [27:0] arg;
    logic        unused_sr;

    assign opcode    = host.host_cmd[31:28];
    assign arg       = host.host_cmd[27:0];
    assign accept    = host.host_cmd_valid && host.host_cmd_ready;
    assign unused_sr = ^sr_in[31:1];

    assign host.host_cmd_ready = (state == IDLE);
    assign busy                = (state != IDLE);
    assign host.rd_data        = host.rd_valid ? shadow[word_idx] : 32'h0;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            corr_cr       <= '0;
            corr_we       <= 1'b0;
            corr_reset    <= 1'b0;
            host.rd_valid <= 1'b0;
            host.rd_last  <= 1'b0;
            err           <= 1'b0;
            tmo_cnt       <= '0;
            pulse_cnt     <= '0;
            word_idx      <= '0;
            for (int i = 0; i < 10; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            4'h0: err <= 1'b0;
                            4'h1: begin
                                corr_cr <= {4'h0, arg};
                                corr_we <= 1'b1;
                                state   <= WRITE;
                            end
                            4'h2: begin
                                pulse_cnt  <= arg[7:0];
                                corr_reset <= 1'b1;
                                state      <= RST_PULSE;
                            end
                            4'h3:    state <= SNAP;
                            default: err   <= 1'b1;
                        endcase
                    end
                end
                WRITE: begin
                    corr_we <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (sr_in[0]) begin
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RST_PULSE: begin
                    if (pulse_cnt == 8'd0) begin
                        corr_reset <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                SNAP: begin
                    shadow[0]     <= sum_x_2[63:32];
                    shadow[1]     <= sum_x_2[31:0];
                    shadow[2]     <= sum_y_2[63:32];
                    shadow[3]     <= sum_y_2[31:0];
                    shadow[4]     <= sum_xy[63:32];
                    shadow[5]     <= sum_xy[31:0];
                    shadow[6]     <= sum_xy90[63:32];
                    shadow[7]     <= sum_xy90[31:0];
                    shadow[8]     <= sum_y90_2[63:32];
                    shadow[9]     <= sum_y90_2[31:0];
                    word_idx      <= '0;
                    host.rd_valid <= 1'b1;
                    host.rd_last  <= 1'b0;
                    state         <= STREAM;
                end
                STREAM: begin
                    // rd_valid is always high here, so rd_ready alone completes a beat
                    if (host.rd_ready) begin
                        if (word_idx == 4'd9) begin
                            host.rd_valid <= 1'b0;
                            host.rd_last  <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            word_idx     <= word_idx + 4'd1;
                            host.rd_last <= (word_idx == 4'd8);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_master_ctrl.sv
// Self-checking bench for corr_master_ctrl; readout words are predicted into a
// queue when READ is issued and retired on each rd handshake.
module tb_corr_master_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] corr_cr;
    logic        corr_we, corr_reset, busy, err;
    logic [31:0] sr_in = '0;
    logic [63:0] sum_x_2 = '0, sum_y_2 = '0, sum_xy = '0, sum_xy90 = '0, sum_y90_2 = '0;

    corr_master_ctrl_if bus ();

    corr_master_ctrl #(.ACK_TIMEOUT(16)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .host       (bus.slave),
        .corr_cr    (corr_cr),
        .corr_we    (corr_we),
        .corr_reset (corr_reset),
        .sr_in      (sr_in),
        .sum_x_2    (sum_x_2),
        .sum_y_2    (sum_y_2),
        .sum_xy     (sum_xy),
        .sum_xy90   (sum_xy90),
        .sum_y90_2  (sum_y90_2),
        .busy       (busy),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send_cmd(input logic [31:0] cmd);
        check_eq("cmd_ready", bus.host_cmd_ready, 1'b1);
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd       = cmd;
        tick();
        bus.host_cmd_valid = 1'b0;
        bus.host_cmd       = '0;
    endtask

    task automatic set_sums(input logic [63:0] a, b, c, d, e);
        sum_x_2 = a; sum_y_2 = b; sum_xy = c; sum_xy90 = d; sum_y90_2 = e;
    endtask

    task automatic push_snapshot();
        exp_q.push_back(sum_x_2[63:32]);   exp_q.push_back(sum_x_2[31:0]);
        exp_q.push_back(sum_y_2[63:32]);   exp_q.push_back(sum_y_2[31:0]);
        exp_q.push_back(sum_xy[63:32]);    exp_q.push_back(sum_xy[31:0]);
        exp_q.push_back(sum_xy90[63:32]);  exp_q.push_back(sum_xy90[31:0]);
        exp_q.push_back(sum_y90_2[63:32]); exp_q.push_back(sum_y90_2[31:0]);
    endtask

    task automatic run_read(input bit toggle, input bit change_mid);
        int pops = 0;
        int cyc  = 0;
        bit rdy  = 1'b1;
        push_snapshot();
        send_cmd(32'h3000_0000);
        check_eq("snap_valid_low", bus.rd_valid, 1'b0);
        tick();
        while (exp_q.size() > 0 && cyc < 200) begin
            bus.rd_ready = toggle ? rdy : 1'b1;
            check_eq("rd_valid", bus.rd_valid, 1'b1);
            check_eq("rd_data", bus.rd_data, exp_q[0]);
            check_eq("rd_last", bus.rd_last, exp_q.size() == 1);
            if (bus.rd_ready) begin
                void'(exp_q.pop_front());
                pops++;
                if (change_mid && pops == 3)
                    set_sums({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                             {$urandom, $urandom}, {$urandom, $urandom});
            end
            rdy = ~rdy;
            cyc++;
            tick();
        end
        bus.rd_ready = 1'b0;
        check_eq("rd_drained", exp_q.size(), 0);
        check_eq("rd_valid_after", bus.rd_valid, 1'b0);
        check_eq("rd_data_idle", bus.rd_data, 32'h0);
        check_eq("busy_after_read", busy, 1'b0);
        exp_q.delete();
    endtask

    task automatic rst_pulse(input logic [7:0] arg, input int exp_len);
        int n = 0, mism = 0, cyc = 0;
        send_cmd({4'h2, 20'h0, arg});
        while (busy && cyc < 400) begin
            if (corr_reset) n++;
            if (corr_reset !== busy) mism++;
            cyc++;
            tick();
        end
        check_eq("rst_pulse_len", n, exp_len);
        check_eq("rst_busy_span", mism, 0);
        check_eq("rst_low_after", corr_reset, 1'b0);
    endtask

    initial begin
        int n, cyc, pops;
        bit rdy;
        bus.host_cmd_valid = 1'b0;
        bus.host_cmd       = '0;
        bus.rd_ready       = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        check_eq("rst_ready", bus.host_cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_cr", corr_cr, 32'h0);
        check_eq("rst_we", corr_we, 1'b0);
        check_eq("rst_creset", corr_reset, 1'b0);
        check_eq("rst_rd_valid", bus.rd_valid, 1'b0);
        check_eq("rst_rd_data", bus.rd_data, 32'h0);
        tick();

        // WRCR with ack one cycle after the strobe
        send_cmd(32'h1000_00AB);
        check_eq("wr_we_high", corr_we, 1'b1);
        check_eq("wr_cr", corr_cr, 32'h0000_00AB);
        tick();
        check_eq("wr_we_once", corr_we, 1'b0);
        check_eq("wr_ackwait_busy", busy, 1'b1);
        sr_in = 32'h1;
        tick();
        sr_in = 32'h0;
        check_eq("wr_idle", busy, 1'b0);
        check_eq("wr_err", err, 1'b0);
        check_eq("wr_cr_hold", corr_cr, 32'h0000_00AB);

        // WRCR with no ack: 1 WRITE cycle + 16 ACK_WAIT cycles
        send_cmd(32'h1000_0005);
        check_eq("tmo_we", corr_we, 1'b1);
        n = 0; cyc = 0;
        while (busy && cyc < 100) begin
            n++; cyc++;
            tick();
        end
        check_eq("tmo_busy_len", n, 17);
        check_eq("tmo_err", err, 1'b1);
        check_eq("tmo_cr", corr_cr, 32'h0000_0005);
        send_cmd(32'h0000_0000);
        check_eq("clear_err", err, 1'b0);
        check_eq("clear_idle", busy, 1'b0);

        rst_pulse(8'd3, 4);
        rst_pulse(8'd0, 1);
        rst_pulse(8'd255, 256);

        set_sums(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001);
        run_read(1'b0, 1'b0);
        check_eq("cr_retained", corr_cr, 32'h0000_0005);

        set_sums(64'hAAFF00FF00FF0081, 64'hAAFF00FF00FF0081, 64'hAAFF00FF00FF0081,
                 64'hAAFF00FF00FF0081, 64'hAAFF00FF00FF0081);
        run_read(1'b1, 1'b1);

        send_cmd(32'h7000_0000);
        check_eq("illegal_err", err, 1'b1);
        check_eq("illegal_no_we", corr_we, 1'b0);
        check_eq("illegal_idle", busy, 1'b0);

        // Reset while the 5th word is on the bus
        set_sums(64'hCAFE_0000_BEEF_0001, 64'h2, 64'h3, 64'h4, 64'h5);
        push_snapshot();
        send_cmd(32'h3000_0000);
        tick();
        pops = 0; cyc = 0; rdy = 1'b1;
        while (pops < 4 && cyc < 50) begin
            bus.rd_ready = rdy;
            if (bus.rd_valid && rdy) begin
                void'(exp_q.pop_front());
                pops++;
            end
            rdy = ~rdy;
            cyc++;
            tick();
        end
        check_eq("mid_word5", bus.rd_data, exp_q[0]);
        bus.rd_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        check_eq("mid_rd_valid", bus.rd_valid, 1'b0);
        check_eq("mid_rd_last", bus.rd_last, 1'b0);
        check_eq("mid_rd_data", bus.rd_data, 32'h0);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_err", err, 1'b0);
        check_eq("mid_cr", corr_cr, 32'h0);
        check_eq("mid_we", corr_we, 1'b0);
        check_eq("mid_creset", corr_reset, 1'b0);
        bus.rd_ready = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        check_eq("post_rst_ready", bus.host_cmd_ready, 1'b1);
        tick();
        check_eq("post_rst_valid", bus.rd_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
